// File: rtl/controlador_passo_botao.sv
// Button-driven step sequencer.
// Synchronizes and debounces a raw push-button and turns each confirmed press
// into one single-cycle step pulse. It can also generate periodic automatic
// steps. The step pulse drives the step input of the 2-bit state machine.
module controlador_passo_botao #(
    parameter int DEBOUNCE_CICLOS = 4,   // consecutive equal samples to confirm an edge (2..255)
    parameter int AUTO_PERIODO    = 8    // cycles between automatic steps (2..255)
) (
    input  logic       clock,
    input  logic       reset,            // asynchronous, active low
    input  logic       botao_bruto,      // raw button, may bounce
    input  logic       modo_auto,
    input  logic       habilita,
    output logic       passo,
    output logic       botao_estavel,
    output logic       ocupado,
    output logic [7:0] contagem_passos
);

    localparam logic [7:0] LP_DEB_FIM  = 8'(DEBOUNCE_CICLOS - 1);
    localparam logic [7:0] LP_AUTO_FIM = 8'(AUTO_PERIODO - 1);

    typedef enum logic [1:0] {
        OCIOSO         = 2'd0,
        CONFIRMA_PRESS = 2'd1,
        PRESSIONADO    = 2'd2,
        CONFIRMA_SOLTA = 2'd3
    } estado_t;

    logic       r_s1;
    logic       r_s2;
    estado_t    r_estado;
    logic [7:0] r_cnt;
    logic [7:0] r_auto_cnt;
    logic       r_passo;
    logic       r_botao_estavel;
    logic       r_ocupado;
    logic [7:0] r_contagem;

    logic w_req_manual;
    logic w_auto_ativo;
    logic w_req_auto;
    logic w_emite;

    // The press is confirmed on the edge that sees the last required high sample.
    assign w_req_manual = (r_estado == CONFIRMA_PRESS) && r_s2 && (r_cnt == LP_DEB_FIM);
    assign w_auto_ativo = modo_auto && habilita;
    assign w_req_auto   = w_auto_ativo && (r_auto_cnt == LP_AUTO_FIM);

    // Requests that coincide merge into one pulse. A request that falls on the
    // cycle right after a pulse is dropped, so passo is never high on two
    // consecutive cycles. Only a manual confirmation can land there, because
    // every pulse restarts the auto period.
    assign w_emite = habilita && (w_req_manual || w_req_auto) && !r_passo;

    // Two-flop synchronizer for the asynchronous button.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= botao_bruto;
            r_s2 <= r_s1;
        end
    end

    // Debounce FSM with registered stable-level and busy outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado        <= OCIOSO;
            r_cnt           <= 8'd0;
            r_botao_estavel <= 1'b0;
            r_ocupado       <= 1'b0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (r_s2) begin
                        r_estado  <= CONFIRMA_PRESS;
                        r_cnt     <= 8'd1;
                        r_ocupado <= 1'b1;
                    end
                end
                CONFIRMA_PRESS: begin
                    if (!r_s2) begin
                        // Bounce: give up without a pulse.
                        r_estado  <= OCIOSO;
                        r_cnt     <= 8'd0;
                        r_ocupado <= 1'b0;
                    end else if (r_cnt == LP_DEB_FIM) begin
                        r_estado        <= PRESSIONADO;
                        r_cnt           <= 8'd0;
                        r_botao_estavel <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                PRESSIONADO: begin
                    if (!r_s2) begin
                        r_estado <= CONFIRMA_SOLTA;
                        r_cnt    <= 8'd1;
                    end
                end
                CONFIRMA_SOLTA: begin
                    if (r_s2) begin
                        r_estado <= PRESSIONADO;
                        r_cnt    <= 8'd0;
                    end else if (r_cnt == LP_DEB_FIM) begin
                        r_estado        <= OCIOSO;
                        r_cnt           <= 8'd0;
                        r_botao_estavel <= 1'b0;
                        r_ocupado       <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_estado        <= OCIOSO;
                    r_cnt           <= 8'd0;
                    r_botao_estavel <= 1'b0;
                    r_ocupado       <= 1'b0;
                end
            endcase
        end
    end

    // Auto-step timer: held at zero when disabled, and restarted by every issued pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_auto_cnt <= 8'd0;
        end else if (!w_auto_ativo || w_req_auto || w_emite) begin
            r_auto_cnt <= 8'd0;
        end else begin
            r_auto_cnt <= r_auto_cnt + 8'd1;
        end
    end

    // Registered step pulse and wrapping pulse counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_passo    <= 1'b0;
            r_contagem <= 8'd0;
        end else begin
            r_passo <= w_emite;
            if (w_emite) begin
                r_contagem <= r_contagem + 8'd1;
            end
        end
    end

    assign passo           = r_passo;
    assign botao_estavel   = r_botao_estavel;
    assign ocupado         = r_ocupado;
    assign contagem_passos = r_contagem;

endmodule

// File: tb/tb_controlador_passo_botao.sv
// Self-checking bench for controlador_passo_botao: a vector table, directed
// multi-cycle sequences, and randomized stimulus against a behavioural model.
module tb_controlador_passo_botao;

    localparam int D = 4;
    localparam int P = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       botao_bruto = 1'b0;
    logic       modo_auto = 1'b0;
    logic       habilita = 1'b0;
    logic       passo;
    logic       botao_estavel;
    logic       ocupado;
    logic [7:0] contagem_passos;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    controlador_passo_botao #(
        .DEBOUNCE_CICLOS(D),
        .AUTO_PERIODO   (P)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .botao_bruto    (botao_bruto),
        .modo_auto      (modo_auto),
        .habilita       (habilita),
        .passo          (passo),
        .botao_estavel  (botao_estavel),
        .ocupado        (ocupado),
        .contagem_passos(contagem_passos)
    );

    // Behavioural model: the stable level flips after D consecutive
    // synchronized samples that disagree with it; a 0->1 flip requests a step.
    bit m_s1, m_s2, m_nivel, m_passo;
    int m_run, m_idade, m_cnt;

    task automatic model_reset();
        m_s1 = 0; m_s2 = 0; m_nivel = 0; m_passo = 0;
        m_run = 0; m_idade = 0; m_cnt = 0;
    endtask

    task automatic model_edge();
        bit man, aut, emit, ativo;
        man = 0;
        if (m_s2 != m_nivel) begin
            m_run++;
            if (m_run == D) begin
                m_nivel = !m_nivel;
                m_run   = 0;
                man     = m_nivel;
            end
        end else begin
            m_run = 0;
        end
        ativo = modo_auto && habilita;
        m_idade = ativo ? m_idade + 1 : 0;
        aut  = ativo && (m_idade == P);
        emit = habilita && (man || aut) && !m_passo;
        if (aut || emit) m_idade = 0;
        m_passo = emit;
        if (emit) m_cnt = (m_cnt + 1) % 256;
        m_s2 = m_s1;
        m_s1 = botao_bruto;
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
        end
    endtask

    task automatic check_model(input string nome);
        logic [10:0] got, exp;
        got = {passo, botao_estavel, ocupado, contagem_passos};
        exp = {m_passo, m_nivel, (m_nivel || m_run > 0), 8'(m_cnt)};
        check(nome, 32'(got), 32'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        botao_bruto = 1'b0;
        modo_auto = 1'b0;
        habilita = 1'b1;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic       b;
        logic       m;
        logic       h;
        logic       ep;
        logic       ee;
        logic       eo;
        logic [7:0] ec;
    } vec_t;

    vec_t tab[17];

    initial begin
        int pulsos, run_left;

        // Press held 10 cycles then released; row i = inputs before edge i+1, outputs after it.
        for (int i = 0; i < 10; i++) tab[i] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        for (int i = 10; i < 17; i++) tab[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'd1};
        tab[2].eo = 1'b1; tab[3].eo = 1'b1; tab[4].eo = 1'b1;
        tab[5].ep = 1'b1; tab[5].ee = 1'b1; tab[5].eo = 1'b1; tab[5].ec = 8'd1;
        for (int i = 6; i < 10; i++) begin
            tab[i].ee = 1'b1; tab[i].eo = 1'b1; tab[i].ec = 8'd1;
        end
        tab[15].ee = 1'b0; tab[15].eo = 1'b0;
        tab[16].ee = 1'b0; tab[16].eo = 1'b0;

        do_reset();
        check("reset_state", {28'd0, passo, botao_estavel, ocupado, |contagem_passos}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            botao_bruto = tab[i].b;
            modo_auto   = tab[i].m;
            habilita    = tab[i].h;
            tick();
            check($sformatf("tab[%0d]", i), {passo, botao_estavel, ocupado, contagem_passos},
                  {tab[i].ep, tab[i].ee, tab[i].eo, tab[i].ec});
        end

        // Long hold: exactly one pulse, no auto-repeat.
        pulsos = 0;
        botao_bruto = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            pulsos += int'(passo);
        end
        check("hold_pulses", pulsos, 1);
        check("hold_count", contagem_passos, 8'd2);
        check("hold_estavel", botao_estavel, 1'b1);

        // Bounce: 2 high, 1 low, five times, then low.
        do_reset();
        pulsos = 0;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 3; j++) begin
                botao_bruto = (j < 2);
                tick();
                pulsos += int'(passo);
            end
        end
        botao_bruto = 1'b0;
        repeat (6) begin
            tick();
            pulsos += int'(passo);
        end
        check("bounce_pulses", pulsos, 0);
        check("bounce_ocupado", ocupado, 1'b0);
        check("bounce_estavel", botao_estavel, 1'b0);

        // Auto stepping: pulses at edges 8,16,24,32,40.
        do_reset();
        modo_auto = 1'b1;
        habilita  = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            check($sformatf("auto_e%0d", i), passo, (i % P == 0));
        end
        check("auto_count", contagem_passos, 8'd5);

        // Collision: manual confirmation lands on the edge-16 auto pulse.
        do_reset();
        modo_auto = 1'b1;
        habilita  = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            botao_bruto = (i >= 11);
            tick();
            if (i >= 14 && i <= 25)
                check($sformatf("coll_e%0d", i), passo, (i == 16 || i == 24));
            if (i == 16) check("coll_count16", contagem_passos, 8'd2);
        end
        check("coll_count", contagem_passos, 8'd3);

        // habilita=0 during a confirmed press: nothing issued, nothing queued.
        do_reset();
        habilita = 1'b0;
        botao_bruto = 1'b1;
        pulsos = 0;
        repeat (10) begin
            tick();
            pulsos += int'(passo);
        end
        check("hab0_estavel", botao_estavel, 1'b1);
        habilita = 1'b1;
        repeat (10) begin
            tick();
            pulsos += int'(passo);
        end
        check("hab0_pulses", pulsos, 0);
        check("hab0_count", contagem_passos, 8'd0);

        // Asynchronous reset in CONFIRMA_PRESS with cnt=2.
        do_reset();
        botao_bruto = 1'b1;
        repeat (4) tick();
        check("midrst_busy", ocupado, 1'b1);
        reset = 1'b0;
        model_reset();
        #2;
        check("midrst_clear", {passo, botao_estavel, ocupado, contagem_passos}, 11'd0);
        #3;
        reset = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            check($sformatf("midrst_e%0d", i), passo, (i == 6));
        end
        check("midrst_count", contagem_passos, 8'd1);

        // Wrap: 256 auto pulses bring the counter back to 0.
        do_reset();
        modo_auto = 1'b1;
        habilita  = 1'b1;
        pulsos = 0;
        for (int i = 1; i <= 256 * P; i++) begin
            tick();
            pulsos += int'(passo);
            if (i == 255 * P) check("wrap_255", contagem_passos, 8'd255);
        end
        check("wrap_pulses", pulsos, 256);
        check("wrap_count", contagem_passos, 8'd0);

        // Randomized stimulus against the model.
        do_reset();
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run_left == 0) begin
                botao_bruto = 1'($urandom_range(0, 1));
                run_left = int'($urandom_range(1, 12));
            end
            run_left--;
            if ($urandom_range(0, 49) == 0) modo_auto = ~modo_auto;
            habilita = ($urandom_range(0, 19) != 0);
            tick();
            check_model("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
